// File: rtl/nzcv_pkg.sv
// ---------------------------------------------------------------------------
// nzcv_pkg
// Shared definitions for the NZCV flags stage:
//   cond_e      - ARMv8 condition codes used by B.cond
//   FLAG_*      - bit positions of N, Z, C, V inside a 4-bit flags vector
//   cond_holds  - evaluates a condition code against a flags vector
// ---------------------------------------------------------------------------
package nzcv_pkg;

    typedef enum logic [3:0] {
        COND_EQ = 4'h0,
        COND_NE = 4'h1,
        COND_CS = 4'h2,
        COND_CC = 4'h3,
        COND_MI = 4'h4,
        COND_PL = 4'h5,
        COND_VS = 4'h6,
        COND_VC = 4'h7,
        COND_HI = 4'h8,
        COND_LS = 4'h9,
        COND_GE = 4'hA,
        COND_LT = 4'hB,
        COND_GT = 4'hC,
        COND_LE = 4'hD,
        COND_AL = 4'hE,
        COND_NV = 4'hF
    } cond_e;

    localparam int FLAG_N = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    function automatic logic cond_holds(cond_e cond, logic [3:0] nzcv);
        logic n, z, c, v;
        logic res;
        n = nzcv[FLAG_N];
        z = nzcv[FLAG_Z];
        c = nzcv[FLAG_C];
        v = nzcv[FLAG_V];
        case (cond)
            COND_EQ: res = z;
            COND_NE: res = ~z;
            COND_CS: res = c;
            COND_CC: res = ~c;
            COND_MI: res = n;
            COND_PL: res = ~n;
            COND_VS: res = v;
            COND_VC: res = ~v;
            COND_HI: res = c & ~z;
            COND_LS: res = ~c | z;
            COND_GE: res = (n == v);
            COND_LT: res = (n != v);
            COND_GT: res = ~z & (n == v);
            COND_LE: res = z | (n != v);
            COND_AL: res = 1'b1;
            // NV is architecturally "always" in AArch64 B.cond
            COND_NV: res = 1'b1;
            default: res = 1'b1;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/cond_eval.sv
// ---------------------------------------------------------------------------
// cond_eval
// Purely combinational condition-code evaluator wrapping cond_holds.
//   cond_i   [3:0]  condition code
//   nzcv_i   [3:0]  flags, [3]=N [2]=Z [1]=C [0]=V
//   holds_o         1 when the condition is satisfied
// ---------------------------------------------------------------------------
module cond_eval
    import nzcv_pkg::*;
(
    input  logic [3:0] cond_i,
    input  logic [3:0] nzcv_i,
    output logic       holds_o
);

    assign holds_o = cond_holds(cond_e'(cond_i), nzcv_i);

endmodule

// File: rtl/nzcv_flags_stage.sv
// ---------------------------------------------------------------------------
// nzcv_flags_stage
// Execute-to-writeback stage behind the NZCV ALU. Single-entry buffer with
// valid/ready on both sides, architectural NZCV register, B.cond resolution
// against the committed flags and a taken-branch counter.
//   i_clk, i_rst_n          clock, async active-low reset
//   i_valid / o_ready       upstream handshake
//   i_result, i_nzcv        ALU result and flags
//   i_set_flags             beat commits i_nzcv
//   i_is_bcond, i_cond      conditional branch and its condition code
//   i_flush                 drop the buffered beat and the same-cycle accept
//   o_valid / i_ready       downstream handshake
//   o_result, o_taken       buffered result / branch taken
//   o_flags                 architectural NZCV register
//   o_taken_cnt             accepted taken branches, wraps
// ---------------------------------------------------------------------------
module nzcv_flags_stage #(
    parameter int N     = 64,
    parameter int CNT_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [N-1:0]     i_result,
    input  logic [3:0]       i_nzcv,
    input  logic             i_set_flags,
    input  logic             i_is_bcond,
    input  logic [3:0]       i_cond,
    input  logic             i_flush,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [N-1:0]     o_result,
    output logic [3:0]       o_flags,
    output logic             o_taken,
    output logic [CNT_W-1:0] o_taken_cnt
);

    logic             valid_q, valid_d;
    logic [N-1:0]     result_q, result_d;
    logic [3:0]       flags_q, flags_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic accept;
    logic xfer;
    logic cond_true;

    // Condition is judged against the flags committed before this beat.
    cond_eval u_cond_eval (
        .cond_i  (i_cond),
        .nzcv_i  (flags_q),
        .holds_o (cond_true)
    );

    assign o_ready = ~valid_q | i_ready;
    assign accept  = i_valid & o_ready;
    assign xfer    = valid_q & i_ready;

    always_comb begin
        valid_d  = valid_q;
        result_d = result_q;
        flags_d  = flags_q;
        taken_d  = taken_q;
        cnt_d    = cnt_q;

        if (i_flush) begin
            // Upstream beat is still consumed (o_ready unaffected) but dropped.
            valid_d = 1'b0;
            taken_d = 1'b0;
        end else if (accept) begin
            valid_d  = 1'b1;
            result_d = i_result;
            taken_d  = i_is_bcond & cond_true;
            if (i_set_flags) begin
                flags_d = i_nzcv;
            end
            if (i_is_bcond & cond_true) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            flags_q  <= 4'b0000;
            taken_q  <= 1'b0;
            cnt_q    <= '0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            flags_q  <= flags_d;
            taken_q  <= taken_d;
            cnt_q    <= cnt_d;
        end
    end

    assign o_valid     = valid_q;
    assign o_result    = result_q;
    assign o_flags     = flags_q;
    assign o_taken     = taken_q;
    assign o_taken_cnt = cnt_q;

endmodule

// File: tb/tb_nzcv_flags_stage.sv
module tb_nzcv_flags_stage;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_valid;
    logic        o_ready;
    logic [63:0] i_result;
    logic [3:0]  i_nzcv;
    logic        i_set_flags;
    logic        i_is_bcond;
    logic [3:0]  i_cond;
    logic        i_flush;
    logic        o_valid;
    logic        i_ready;
    logic [63:0] o_result;
    logic [3:0]  o_flags;
    logic        o_taken;
    logic [15:0] o_taken_cnt;

    int total = 0;
    int bad   = 0;

    nzcv_flags_stage #(.N(64), .CNT_W(16)) dut (
        .i_clk       (i_clk),
        .i_rst_n     (i_rst_n),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_result    (i_result),
        .i_nzcv      (i_nzcv),
        .i_set_flags (i_set_flags),
        .i_is_bcond  (i_is_bcond),
        .i_cond      (i_cond),
        .i_flush     (i_flush),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_flags     (o_flags),
        .o_taken     (o_taken),
        .o_taken_cnt (o_taken_cnt)
    );

    always #5 i_clk = ~i_clk;

    // ARM pseudocode form: base test from cond[3:1], inverted by cond[0]
    // except for 1111.
    function automatic bit m_cond(logic [3:0] c, logic [3:0] f);
        bit n, z, cy, v, r;
        n = f[3]; z = f[2]; cy = f[1]; v = f[0];
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cy;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cy && !z;
            3'd5: r = (n == v);
            3'd6: r = (n == v) && !z;
            default: r = 1'b1;
        endcase
        if (c[0] && c != 4'hF) r = !r;
        return r;
    endfunction

    // Reference state of the stage.
    bit          m_valid;
    logic [63:0] m_result;
    logic [3:0]  m_flags;
    bit          m_taken;
    logic [15:0] m_cnt;

    always @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            m_valid = 0; m_result = '0; m_flags = 4'b0000; m_taken = 0; m_cnt = '0;
        end else begin
            bit rdy, acc, tk;
            rdy = !m_valid || i_ready;
            acc = i_valid && rdy;
            if (i_flush) begin
                m_valid = 0;
                m_taken = 0;
            end else if (acc) begin
                tk = i_is_bcond && m_cond(i_cond, m_flags);
                m_valid  = 1;
                m_result = i_result;
                m_taken  = tk;
                if (i_set_flags) m_flags = i_nzcv;
                if (tk) m_cnt = m_cnt + 16'd1;
            end else if (m_valid && i_ready) begin
                m_valid = 0;
            end
        end
    end

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    bit chk_en = 0;

    always @(negedge i_clk) begin
        if (chk_en) begin
            check("cmp_ready",  64'(o_ready),     64'(!m_valid || i_ready));
            check("cmp_valid",  64'(o_valid),     64'(m_valid));
            check("cmp_result", o_result,         m_result);
            check("cmp_flags",  64'(o_flags),     64'(m_flags));
            check("cmp_taken",  64'(o_taken),     64'(m_taken));
            check("cmp_cnt",    64'(o_taken_cnt), 64'(m_cnt));
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #2;
    endtask

    task automatic set_beat(logic v, logic [63:0] r, logic [3:0] f, logic sf,
                            logic bc, logic [3:0] c);
        i_valid = v; i_result = r; i_nzcv = f; i_set_flags = sf;
        i_is_bcond = bc; i_cond = c;
    endtask

    initial begin
        i_rst_n = 1'b0;
        i_flush = 1'b0;
        i_ready = 1'b1;
        set_beat(0, '0, 4'h0, 0, 0, 4'h0);

        check("model_lt",  64'(m_cond(4'b1011, 4'b1000)), 64'd1);
        check("model_gt",  64'(m_cond(4'b1100, 4'b0100)), 64'd0);
        check("model_nv",  64'(m_cond(4'b1111, 4'b0000)), 64'd1);
        check("model_ls",  64'(m_cond(4'b1001, 4'b0010)), 64'd0);

        #12 i_rst_n = 1'b1;
        chk_en = 1;
        tick();
        check("rst_valid", 64'(o_valid), 64'd0);
        check("rst_ready", 64'(o_ready), 64'd1);
        check("rst_flags", 64'(o_flags), 64'd0);
        check("rst_cnt",   64'(o_taken_cnt), 64'd0);

        set_beat(1, 64'h8000_0000_0000_0000, 4'b1000, 1, 0, 4'h0);
        tick();
        check("b1_valid",  64'(o_valid), 64'd1);
        check("b1_result", o_result, 64'h8000_0000_0000_0000);
        check("b1_flags",  64'(o_flags), 64'h8);

        set_beat(1, 64'h1, 4'h0, 0, 1, 4'b1011);
        tick();
        check("lt_taken", 64'(o_taken), 64'd1);
        check("lt_cnt",   64'(o_taken_cnt), 64'd1);

        set_beat(1, 64'h2, 4'h0, 0, 1, 4'b1010);
        tick();
        check("ge_taken", 64'(o_taken), 64'd0);
        check("ge_cnt",   64'(o_taken_cnt), 64'd1);

        set_beat(1, 64'h3, 4'b0000, 1, 0, 4'h0);
        tick();
        set_beat(1, 64'h4, 4'b0100, 1, 1, 4'b0000);
        tick();
        check("eqold_taken", 64'(o_taken), 64'd0);
        check("eqold_flags", 64'(o_flags), 64'h4);
        set_beat(1, 64'h5, 4'h0, 0, 1, 4'b0000);
        tick();
        check("eq_taken", 64'(o_taken), 64'd1);
        check("eq_cnt",   64'(o_taken_cnt), 64'd2);
        set_beat(0, '0, 4'h0, 0, 0, 4'h0);
        tick();
        check("idle_valid", 64'(o_valid), 64'd0);

        // back-pressure
        i_ready = 1'b0;
        set_beat(1, 64'hAAAA, 4'b0001, 1, 1, 4'hE);
        tick();
        set_beat(1, 64'hBBBB, 4'b1111, 1, 1, 4'hE);
        for (int k = 0; k < 5; k++) begin
            check("bp_ready",  64'(o_ready), 64'd0);
            check("bp_valid",  64'(o_valid), 64'd1);
            check("bp_result", o_result, 64'hAAAA);
            check("bp_flags",  64'(o_flags), 64'h1);
            check("bp_cnt",    64'(o_taken_cnt), 64'd3);
            tick();
        end
        i_ready = 1'b1;
        tick();
        check("bp_rel_result", o_result, 64'hBBBB);
        check("bp_rel_flags",  64'(o_flags), 64'hF);
        check("bp_rel_cnt",    64'(o_taken_cnt), 64'd4);

        for (int k = 0; k < 4; k++) begin
            set_beat(1, 64'(256 + k), 4'h0, 0, 0, 4'h0);
            tick();
            check("stream_valid",  64'(o_valid), 64'd1);
            check("stream_result", o_result, 64'(256 + k));
        end

        // flush with a taken, flag-setting beat in the same cycle
        set_beat(1, 64'hDEAD, 4'b0000, 1, 1, 4'hE);
        i_flush = 1'b1;
        tick();
        i_flush = 1'b0;
        set_beat(0, '0, 4'h0, 0, 0, 4'h0);
        check("fl_valid", 64'(o_valid), 64'd0);
        check("fl_taken", 64'(o_taken), 64'd0);
        check("fl_flags", 64'(o_flags), 64'hF);
        check("fl_cnt",   64'(o_taken_cnt), 64'd4);

        // async reset while a beat is held
        i_ready = 1'b0;
        set_beat(1, 64'h77, 4'h0, 0, 1, 4'hE);
        tick();
        check("ar_pre_valid", 64'(o_valid), 64'd1);
        #1 i_rst_n = 1'b0;
        #1;
        check("ar_valid", 64'(o_valid), 64'd0);
        check("ar_flags", 64'(o_flags), 64'd0);
        check("ar_cnt",   64'(o_taken_cnt), 64'd0);
        @(negedge i_clk);
        #1 i_rst_n = 1'b1;
        tick();

        // randomized traffic against the model
        for (int k = 0; k < 3000; k++) begin
            set_beat(1'($urandom_range(0, 1)), {$urandom, $urandom}, 4'($urandom),
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom));
            i_ready = ($urandom_range(0, 9) < 7);
            i_flush = ($urandom_range(0, 19) == 0);
            tick();
        end
        i_flush = 1'b0;

        // counter wrap
        i_rst_n = 1'b0;
        #1 i_rst_n = 1'b1;
        i_ready = 1'b1;
        set_beat(1, 64'h0, 4'h0, 0, 1, 4'hE);
        for (int k = 0; k < 65535; k++) tick();
        check("wrap_ffff", 64'(o_taken_cnt), 64'hFFFF);
        tick();
        check("wrap_zero", 64'(o_taken_cnt), 64'h0);
        set_beat(0, '0, 4'h0, 0, 0, 4'h0);
        tick();

        chk_en = 0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/nzcv_flags_stage.md
Name: nzcv_flags_stage

Overview:
- Execute-to-writeback stage downstream of the NZCV-extended ALU.
- Registers the ALU result and holds the architectural NZCV flag register, updated only by flag-setting instructions.
- Resolves conditional branches (B.cond) against the committed flags.
- Single-entry pipeline buffer with valid/ready handshake on both sides; also keeps a taken-branch event counter.

Parameters:
N, 64, datapath width of the ALU result
CNT_W, 16, width of the taken-branch counter

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  asynchronous active-low reset
i_valid  input  1  upstream beat valid
o_ready  output  1  stage can accept a beat
i_result  input  N  ALU result
i_nzcv  input  4  ALU flags: [3]=N [2]=Z [1]=C [0]=V
i_set_flags  input  1  beat commits i_nzcv to the flag register
i_is_bcond  input  1  beat is a conditional branch
i_cond  input  4  ARMv8 condition code for B.cond
i_flush  input  1  synchronous flush of the buffered beat
o_valid  output  1  output beat valid
i_ready  input  1  downstream accepts the beat
o_result  output  N  buffered result
o_flags  output  4  architectural NZCV register, same bit order
o_taken  output  1  buffered beat is a B.cond whose condition held
o_taken_cnt  output  CNT_W  count of accepted taken branches

Behaviour:
- Reset (async, i_rst_n=0): clears all registers immediately, with no clock edge needed.
  - o_valid=0, o_result=0, o_flags=4'b0000, o_taken=0, o_taken_cnt=0.
  - o_ready=1 once out of reset.
  - Reset mid-transfer drops the buffered beat. Flags are not preserved.
- Handshake:
  - o_ready = ~o_valid | i_ready (combinational, full-throughput pass-through). o_ready does not depend on i_valid.
  - Accept = i_valid & o_ready. Output transfer = o_valid & i_ready.
  - On accept: o_result, o_taken and o_valid are loaded at the next edge, so latency is 1 cycle.
  - Transfer without a new accept clears o_valid.
  - Simultaneous transfer and accept replaces the entry; there is no bubble.
  - o_valid=1 & i_ready=0: the entry and all outputs hold stable, and o_ready=0.
- Flag register:
  - Updated at the accept edge iff i_set_flags=1: o_flags <= i_nzcv.
  - Not updated when the beat is only buffered-in without i_set_flags, and not updated on flush.
- Condition evaluation:
  - Combinational on the current o_flags, i.e. the pre-update value, at accept. o_taken <= i_is_bcond & cond_true.
  - If i_set_flags and i_is_bcond are both set on one beat, the condition uses the old flags, then the flags update.
  - Conditions, with N,Z,C,V taken from o_flags:
    - 0000 EQ Z; 0001 NE ~Z
    - 0010 CS C; 0011 CC ~C
    - 0100 MI N; 0101 PL ~N
    - 0110 VS V; 0111 VC ~V
    - 1000 HI C&~Z; 1001 LS ~C|Z
    - 1010 GE N==V; 1011 LT N!=V
    - 1100 GT ~Z&(N==V); 1101 LE Z|(N!=V)
    - 1110 AL 1; 1111 NV 1 (treated as always)
- Taken counter: increments by 1 at each accept with a resulting taken=1. It wraps modulo 2^CNT_W from all-ones to 0.
- Flush (i_flush=1 at an edge):
  - o_valid <= 0 and o_taken <= 0; the same-cycle accept is discarded.
  - o_ready is still asserted combinationally, so the upstream beat is consumed and dropped.
  - That beat's flag update and counter increment are suppressed.
  - Flags already committed by earlier beats remain.
- No X propagation: o_result and o_taken retain their last value while o_valid=0.

Decomposition:
- Package nzcv_pkg holds:
  - cond_e enum of the 16 condition codes.
  - Flag bit index constants FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0.
  - A function cond_holds(cond_e, logic [3:0] nzcv).
- One sub-module, cond_eval: purely combinational. It wraps cond_holds so the verifier can test it exhaustively and in isolation.
- The pipeline register, flag register and counter stay in nzcv_flags_stage.

Test Plan:
- Reset then idle -> o_valid=0, o_ready=1, o_flags=0000, o_taken_cnt=0. Assert i_rst_n=0 mid-transfer -> o_valid drops without a clock edge.
- Beat result=64'h8000_0000_0000_0000, nzcv=1000, set_flags=1 -> next cycle o_valid=1, o_result matches, o_flags=1000.
- Then B.cond cond=1011 (LT) with flags 1000 -> o_taken=1, cnt=1. Then cond=1010 (GE) -> o_taken=0, cnt stays 1.
- Same beat set_flags=1, nzcv=0100, is_bcond=1, cond=0000 (EQ), old flags 0000 -> o_taken=0, o_flags becomes 0100. Next B.cond EQ -> o_taken=1.
- Back-pressure: i_ready=0 with o_valid=1 -> o_ready=0, outputs stable for 5 cycles. A pending i_valid beat with set_flags=1 leaves o_flags unchanged until accepted. Streaming with i_ready=1 -> one beat per cycle, no bubbles.
- Flush with accept of a taken B.cond and set_flags=1 -> o_valid=0, flags and counter unchanged. Preload the counter to FFFF via 65535 taken branches, then one more -> 0000.
